multicyc_bus_responder: RTL and testbench
=========================================

# multicyc_bus_responder

Memory-side responder for the multicycle core's data port: it receives the address, read and write strobes and write data that the core drives, and returns read data. Behind that port it contains a word-addressed data RAM and a memory-mapped peripheral block. The peripheral block provides a reload timer with interrupt, an LED register, a switch input and a free-running cycle counter. It sits between the core's data-memory pins and the board I/O, and its interrupt output goes back to the core.

## Interface
- RAM_WORDS, 256: data RAM depth in 32-bit words; power of two, at most 256 (fits the 1 KiB RAM window).
- PERIPH_BASE, 32'h40000000: base address of the peripheral register window.
- iClk  input  1  system clock; all state updates on the rising edge.
- iRst  input  1  reset; one clock, asynchronous, active-high.
- iAddr  input  32  byte address from the core; iAddr[1:0] ignored (word access only).
- iMemRead  input  1  read strobe.
- iMemWrite  input  1  write strobe.
- iWrData  input  32  write data.
- oRdData  output  32  read data, combinational from iAddr/iMemRead and current state.
- iSwitch  input  8  board switches, sampled through a 2-flop synchronizer.
- oLed  output  8  LED register.
- oIrq  output  1  timer interrupt request, equal to TCON[2].

## Operation
- Address decode:
  - RAM: iAddr[31:10]==0, word index iAddr[log2(RAM_WORDS)+1:2].
  - Peripheral registers: iAddr[31:5]==PERIPH_BASE[31:5], register select iAddr[4:2].
  - Peripheral offsets: 0x00 TH (RW), 0x04 TL (RW), 0x08 TCON (RW, bits[2:0]), 0x0C LED (RW, bits[7:0]), 0x10 SWITCH (RO), 0x14 SYSTICK (RO).
  - Offsets 0x18/0x1C and all other addresses: reads return 0, writes have no effect.
- Reads:
  - oRdData = selected word when iMemRead=1; oRdData = 0 when iMemRead=0.
  - Unused upper bits of TCON, LED and SWITCH read as 0.
- Writes: take effect on the rising edge when iMemWrite=1. Writes to SWITCH and SYSTICK are ignored.
- Simultaneous iMemRead and iMemWrite to the same word: the write is performed, and oRdData in that cycle shows the pre-write value.
- TCON bits: [0] timer enable, [1] interrupt enable, [2] interrupt status.
- Timer, evaluated every cycle while TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL <= TH (overflow), and TCON[2] <= 1 if TCON[1]=1.
  - Otherwise TL <= TL+1.
  - While TCON[0]=0, TL holds its value.
- Collision rules:
  - A core write to TL in the same cycle as an increment or reload wins: TL takes iWrData.
  - A core write to TCON in the same cycle as an overflow: TCON[1:0] <= iWrData[1:0], and TCON[2] <= iWrData[2] | (overflow & TCON[1]). An interrupt is never lost.
  - Software clears the interrupt by writing TCON[2]=0.
- SYSTICK: increments by 1 every cycle out of reset and wraps from 32'hFFFFFFFF to 0.
- SWITCH: reads return the second synchronizer stage.
- Reset (asynchronous, while iRst=1):
  - TH=0, TL=0, TCON=0, LED=0, SYSTICK=0, synchronizer flops=0.
  - oLed=0, oIrq=0. oRdData=0 provided iMemRead=0.
  - RAM contents are not reset.
  - Reset asserted mid-count stops the timer immediately; a pending IRQ is cleared.

## Timing
- Read latency 0: oRdData is valid in the same cycle as iAddr/iMemRead, before the next rising edge.
- Write latency 1: the written value is readable from the cycle after the write edge.
- oIrq rises 1 cycle after the edge at which TL==32'hFFFFFFFF was sampled with TCON[1:0]=2'b11, i.e. in the same cycle TL shows TH.
- Timer period with TH=T: (2^32 − T) cycles between overflows.
- SWITCH: 2-cycle synchronizer delay, so an iSwitch change is visible on read 2 edges later.
- SYSTICK reads 0 during the first cycle after reset deassertion and increments on each edge thereafter.

## Test plan
- RAM write/read:
  - Write 32'hDEADBEEF to 0x00000010, read 0x00000010 next cycle -> 32'hDEADBEEF.
  - Read 0x00000011 -> same word (low bits ignored).
  - Read 0x00000400 -> 0.
- Timer overflow and IRQ:
  - Program TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, TCON=3 -> TL steps FD, FE, FF.
  - Edge 4: TL=32'hFFFFFFFC and oIrq=1; the next overflow comes 4 cycles later.
- IRQ clear collision:
  - Write TCON=32'h3 (clears bit2) in the same cycle TL==32'hFFFFFFFF -> TCON reads 7, oIrq stays 1.
  - A later plain write of 3 -> oIrq=0.
- Register access and peripherals:
  - Write LED=32'h1A5 -> oLed=8'hA5, LED reads 32'h000000A5.
  - Drive iSwitch=8'h3C -> SWITCH reads 8'h3C 2 cycles later.
  - Writes to SYSTICK and to 0x40000018 have no effect.
- Reset mid-operation:
  - Assert iRst asynchronously while the timer runs and oIrq=1 -> oIrq, oLed, TL and SYSTICK go to 0 without waiting for a clock edge.
  - After release, SYSTICK counts 0, 1, 2.
- Read strobe gating: iMemRead=0 with iAddr=0x40000014 -> oRdData=0. Simultaneous read/write of LED -> old value returned that cycle, new value the next.

Source files
------------

// File: rtl/multicyc_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : multicyc_bus_responder_if
// Description : Data-port bus between the multicycle core and its responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicyc_bus_responder_if;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWrData;
    logic [31:0] oRdData;

    modport master (
        output iAddr,
        output iMemRead,
        output iMemWrite,
        output iWrData,
        input  oRdData
    );

    modport slave (
        input  iAddr,
        input  iMemRead,
        input  iMemWrite,
        input  iWrData,
        output oRdData
    );
endinterface
`default_nettype wire

// File: rtl/multicyc_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : multicyc_bus_responder
// Description : Data RAM plus timer/LED/switch/systick peripheral window.
// Revision    : 1.0 - initial release
// ============================================================================
module multicyc_bus_responder #(
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  wire logic                    iClk,
    input  wire logic                    iRst,
    multicyc_bus_responder_if.slave      bus,
    input  wire logic [7:0]              iSwitch,
    output logic      [7:0]              oLed,
    output logic                         oIrq
);

    localparam int         c_IDX_W   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [2:0] c_REG_TH  = 3'd0;
    localparam logic [2:0] c_REG_TL  = 3'd1;
    localparam logic [2:0] c_REG_TCON = 3'd2;
    localparam logic [2:0] c_REG_LED = 3'd3;
    localparam logic [2:0] c_REG_SW  = 3'd4;
    localparam logic [2:0] c_REG_TICK = 3'd5;

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_led;
    logic [31:0] r_sysTick;
    logic [7:0]  r_swSync1;
    logic [7:0]  r_swSync2;

    logic               w_ramSel;
    logic               w_periphSel;
    logic [c_IDX_W-1:0] w_ramIdx;
    logic [2:0]         w_regSel;
    logic               w_ramWr;
    logic               w_thWr;
    logic               w_tlWr;
    logic               w_tconWr;
    logic               w_ledWr;
    logic               w_overflow;
    logic               w_irqSet;
    logic [31:0]        w_selData;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_ramSel    = (bus.iAddr[31:10] == 22'd0);
    assign w_periphSel = (bus.iAddr[31:5] == PERIPH_BASE[31:5]);
    assign w_ramIdx    = bus.iAddr[c_IDX_W+1:2];
    assign w_regSel    = bus.iAddr[4:2];

    assign w_ramWr  = bus.iMemWrite && w_ramSel;
    assign w_thWr   = bus.iMemWrite && w_periphSel && (w_regSel == c_REG_TH);
    assign w_tlWr   = bus.iMemWrite && w_periphSel && (w_regSel == c_REG_TL);
    assign w_tconWr = bus.iMemWrite && w_periphSel && (w_regSel == c_REG_TCON);
    assign w_ledWr  = bus.iMemWrite && w_periphSel && (w_regSel == c_REG_LED);

    // Overflow is judged on pre-write state so a same-cycle TCON write
    // cannot swallow an interrupt that was already due.
    assign w_overflow = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
    assign w_irqSet   = w_overflow && r_tcon[1];

    // ------------------------------------------------------------------
    // Read path: zero latency, shows pre-write state during a write
    // ------------------------------------------------------------------
    always_comb begin
        w_selData = 32'd0;
        if (w_ramSel) begin
            w_selData = r_ram[w_ramIdx];
        end else if (w_periphSel) begin
            case (w_regSel)
                c_REG_TH:   w_selData = r_th;
                c_REG_TL:   w_selData = r_tl;
                c_REG_TCON: w_selData = {29'd0, r_tcon};
                c_REG_LED:  w_selData = {24'd0, r_led};
                c_REG_SW:   w_selData = {24'd0, r_swSync2};
                c_REG_TICK: w_selData = r_sysTick;
                default:    w_selData = 32'd0;
            endcase
        end
    end

    assign bus.oRdData = bus.iMemRead ? w_selData : 32'd0;

    // ------------------------------------------------------------------
    // Data RAM: contents intentionally survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (w_ramWr) begin
            r_ram[w_ramIdx] <= bus.iWrData;
        end
    end

    // ------------------------------------------------------------------
    // Timer registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_th <= 32'd0;
        end else if (w_thWr) begin
            r_th <= bus.iWrData;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_tl <= 32'd0;
        end else if (w_tlWr) begin
            r_tl <= bus.iWrData;
        end else if (w_overflow) begin
            r_tl <= r_th;
        end else if (r_tcon[0]) begin
            r_tl <= r_tl + 32'd1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_tcon <= 3'd0;
        end else if (w_tconWr) begin
            r_tcon <= {bus.iWrData[2] | w_irqSet, bus.iWrData[1:0]};
        end else if (w_irqSet) begin
            r_tcon[2] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // LED, switch synchronizer, free-running tick counter
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_led <= 8'd0;
        end else if (w_ledWr) begin
            r_led <= bus.iWrData[7:0];
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_swSync1 <= 8'd0;
            r_swSync2 <= 8'd0;
        end else begin
            r_swSync1 <= iSwitch;
            r_swSync2 <= r_swSync1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_sysTick <= 32'd0;
        end else begin
            r_sysTick <= r_sysTick + 32'd1;
        end
    end

    assign oLed = r_led;
    assign oIrq = r_tcon[2];

endmodule
`default_nettype wire

// File: tb/tb_multicyc_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicyc_bus_responder
// Description : Directed, table-driven self-checking bench for the responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicyc_bus_responder;

    localparam logic [31:0] c_TH   = 32'h4000_0000;
    localparam logic [31:0] c_TL   = 32'h4000_0004;
    localparam logic [31:0] c_TCON = 32'h4000_0008;
    localparam logic [31:0] c_LED  = 32'h4000_000C;
    localparam logic [31:0] c_SW   = 32'h4000_0010;
    localparam logic [31:0] c_TICK = 32'h4000_0014;

    logic       iClk;
    logic       iRst;
    logic [7:0] iSwitch;
    logic [7:0] oLed;
    logic       oIrq;

    int nChecks;
    int nFail;

    multicyc_bus_responder_if bus ();

    multicyc_bus_responder #(
        .RAM_WORDS   (256),
        .PERIPH_BASE (32'h4000_0000)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .bus     (bus.slave),
        .iSwitch (iSwitch),
        .oLed    (oLed),
        .oIrq    (oIrq)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic busIdle();
        bus.iMemRead  = 1'b0;
        bus.iMemWrite = 1'b0;
        bus.iAddr     = 32'd0;
        bus.iWrData   = 32'd0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        bus.iAddr     = addr;
        bus.iWrData   = data;
        bus.iMemWrite = 1'b1;
        bus.iMemRead  = 1'b0;
        tick();
        busIdle();
    endtask

    task automatic readChk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.iAddr    = addr;
        bus.iMemRead = 1'b1;
        #1;
        chk(name, bus.oRdData, exp);
    endtask

    logic [31:0] tickVal;

    initial begin
        nChecks = 0;
        nFail   = 0;
        iRst    = 1'b1;
        iSwitch = 8'h00;
        busIdle();

        vecs[0]  = '{"ram_wr",        1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{"ram_rd",        1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{"ram_rd_lowbits",1'b0, 1'b1, 32'h0000_0011, 32'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{"rd_0x400",      1'b0, 1'b1, 32'h0000_0400, 32'h0,         32'h0};
        vecs[4]  = '{"ram_wr_top",    1'b1, 1'b0, 32'h0000_03FC, 32'h1234_5678, 32'h0};
        vecs[5]  = '{"ram_rd_top",    1'b0, 1'b1, 32'h0000_03FC, 32'h0,         32'h1234_5678};
        vecs[6]  = '{"led_wr",        1'b1, 1'b0, c_LED,         32'h0000_01A5, 32'h0};
        vecs[7]  = '{"led_rd",        1'b0, 1'b1, c_LED,         32'h0,         32'h0000_00A5};
        vecs[8]  = '{"hole_wr",       1'b1, 1'b0, 32'h4000_0018, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{"hole_rd",       1'b0, 1'b1, 32'h4000_0018, 32'h0,         32'h0};
        vecs[10] = '{"th_wr",         1'b1, 1'b0, c_TH,          32'hCAFE_0055, 32'h0};
        vecs[11] = '{"th_rd",         1'b0, 1'b1, c_TH,          32'h0,         32'hCAFE_0055};
        vecs[12] = '{"tcon_wr_upper", 1'b1, 1'b0, c_TCON,        32'hFFFF_FFF8, 32'h0};
        vecs[13] = '{"tcon_rd_upper", 1'b0, 1'b1, c_TCON,        32'h0,         32'h0};
        vecs[14] = '{"rd_gated",      1'b0, 1'b0, c_TICK,        32'h0,         32'h0};
        vecs[15] = '{"led_rw_same",   1'b1, 1'b1, c_LED,         32'h0000_005A, 32'h0000_00A5};

        // Reset state
        tick();
        tick();
        chk("rst_led", {24'd0, oLed}, 32'h0);
        chk("rst_irq", {31'd0, oIrq}, 32'h0);
        chk("rst_rd_idle", bus.oRdData, 32'h0);
        readChk("rst_tl", c_TL, 32'h0);
        busIdle();

        // SYSTICK counts 0,1,2 from release
        tick();
        iRst = 1'b0;
        readChk("tick0", c_TICK, 32'd0);
        tick();
        readChk("tick1", c_TICK, 32'd1);
        tick();
        readChk("tick2", c_TICK, 32'd2);
        busIdle();

        // Table vectors
        for (int i = 0; i < 16; i++) begin
            bus.iAddr     = vecs[i].addr;
            bus.iWrData   = vecs[i].wdata;
            bus.iMemWrite = vecs[i].wr;
            bus.iMemRead  = vecs[i].rd;
            #1;
            chk(vecs[i].name, bus.oRdData, vecs[i].exp);
            tick();
            busIdle();
        end
        readChk("led_rw_next", c_LED, 32'h0000_005A);
        chk("led_port", {24'd0, oLed}, 32'h0000_005A);
        busIdle();

        // SYSTICK write ignored
        bus.iAddr     = c_TICK;
        bus.iMemRead  = 1'b1;
        bus.iMemWrite = 1'b1;
        bus.iWrData   = 32'd0;
        #1;
        tickVal = bus.oRdData;
        tick();
        bus.iMemWrite = 1'b0;
        readChk("tick_wr_ignored", c_TICK, tickVal + 32'd1);
        busIdle();

        // Switch synchronizer: two edges of delay
        iSwitch = 8'h3C;
        tick();
        readChk("sw_1edge", c_SW, 32'h0);
        tick();
        readChk("sw_2edge", c_SW, 32'h0000_003C);
        busIdle();

        // Timer overflow and IRQ
        busWrite(c_TH, 32'hFFFF_FFFC);
        busWrite(c_TL, 32'hFFFF_FFFC);
        busWrite(c_TCON, 32'h3);
        readChk("tl_e0", c_TL, 32'hFFFF_FFFC);
        tick();
        readChk("tl_e1", c_TL, 32'hFFFF_FFFD);
        tick();
        readChk("tl_e2", c_TL, 32'hFFFF_FFFE);
        tick();
        readChk("tl_e3", c_TL, 32'hFFFF_FFFF);
        chk("irq_e3", {31'd0, oIrq}, 32'h0);
        tick();
        readChk("tl_e4_reload", c_TL, 32'hFFFF_FFFC);
        chk("irq_e4", {31'd0, oIrq}, 32'h1);
        tick();
        tick();
        tick();
        readChk("tl_e7", c_TL, 32'hFFFF_FFFF);

        // Clear attempt colliding with the next overflow
        bus.iAddr     = c_TCON;
        bus.iWrData   = 32'h3;
        bus.iMemWrite = 1'b1;
        bus.iMemRead  = 1'b1;
        #1;
        chk("tcon_prewrite", bus.oRdData, 32'h7);
        tick();
        bus.iMemWrite = 1'b0;
        readChk("tcon_collide", c_TCON, 32'h7);
        chk("irq_collide", {31'd0, oIrq}, 32'h1);
        readChk("tl_e8_reload", c_TL, 32'hFFFF_FFFC);
        busIdle();
        busWrite(c_TCON, 32'h3);
        readChk("tcon_clear", c_TCON, 32'h3);
        chk("irq_clear", {31'd0, oIrq}, 32'h0);
        busIdle();

        // Asynchronous reset while the timer runs with IRQ pending
        for (int i = 0; i < 20 && !oIrq; i++) tick();
        chk("irq_again", {31'd0, oIrq}, 32'h1);
        bus.iAddr    = c_TL;
        bus.iMemRead = 1'b1;
        #2;
        iRst = 1'b1;
        #1;
        chk("arst_irq", {31'd0, oIrq}, 32'h0);
        chk("arst_led", {24'd0, oLed}, 32'h0);
        chk("arst_tl", bus.oRdData, 32'h0);
        readChk("arst_tick", c_TICK, 32'h0);
        readChk("arst_tcon", c_TCON, 32'h0);
        busIdle();
        tick();
        iRst = 1'b0;
        readChk("rel_tick0", c_TICK, 32'd0);
        tick();
        readChk("rel_tick1", c_TICK, 32'd1);
        tick();
        readChk("rel_tick2", c_TICK, 32'd2);
        readChk("rel_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        busIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
